// File: rtl/uart_text_pkg.sv
// -----------------------------------------------------------------------------
// uart_text_pkg
// Shared definitions for the UART-to-text-buffer controller:
//   - control-code constants (CR, LF, BS, FF, ESC, SPACE, printable range)
//   - controller state enum
//   - default screen geometry and cursor field widths
//   - is_printable() helper
// -----------------------------------------------------------------------------
package uart_text_pkg;

  // Control codes understood by the controller.
  localparam logic [7:0] CR        = 8'h0D;
  localparam logic [7:0] LF        = 8'h0A;
  localparam logic [7:0] BS        = 8'h08;
  localparam logic [7:0] FF        = 8'h0C;
  localparam logic [7:0] ESC       = 8'h1B;
  localparam logic [7:0] SPACE     = 8'h20;
  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  // Default geometry: 640x480 with an 8x16 font.
  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;

  // Cursor port widths (fixed by the text-buffer consumer).
  localparam int ROW_W = 5;
  localparam int COL_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ESC_ROW = 2'd1,
    ST_ESC_COL = 2'd2,
    ST_CLEAR   = 2'd3
  } state_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_MIN) && (b <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/uart_text_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_text_ctrl_if
// Bundles the UART receiver input, the text-buffer write port and the cursor /
// status outputs of uart_text_ctrl.
//   rx_valid_i / rx_data_i : receiver byte level and data
//   wr_en_o / wr_addr_o / wr_data_o : one-cycle buffer write
//   cur_row_o / cur_col_o  : text cursor
//   busy_o / ovf_o         : clear sweep running / byte lost during a clear
// master : the controller side; slave : the environment (receiver + buffer).
// -----------------------------------------------------------------------------
interface uart_text_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              rx_valid_i;
  logic [7:0]        rx_data_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [7:0]        wr_data_o;
  logic [4:0]        cur_row_o;
  logic [6:0]        cur_col_o;
  logic              busy_o;
  logic              ovf_o;

  modport master (
    input  rx_valid_i, rx_data_i,
    output wr_en_o, wr_addr_o, wr_data_o, cur_row_o, cur_col_o, busy_o, ovf_o
  );

  modport slave (
    output rx_valid_i, rx_data_i,
    input  wr_en_o, wr_addr_o, wr_data_o, cur_row_o, cur_col_o, busy_o, ovf_o
  );
endinterface

// File: rtl/uart_byte_strobe.sv
// -----------------------------------------------------------------------------
// uart_byte_strobe
// Converts a level-style "byte valid" into a single-cycle event carrying the
// byte that was present on the rising edge of the level.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   valid_i      : byte-valid level (held high for many cycles per byte)
//   data_i       : byte, stable while valid_i is high
//   evt_o        : one-cycle pulse per rising edge of valid_i
//   data_o       : byte captured with that rising edge
// -----------------------------------------------------------------------------
module uart_byte_strobe (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       evt_o,
  output logic [7:0] data_o
);

  logic       valid_q;
  logic       evt_q;
  logic [7:0] data_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      evt_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_i;
      evt_q   <= valid_i & ~valid_q;
      if (valid_i && !valid_q) begin
        data_q <= data_i;
      end
    end
  end

  assign evt_o  = evt_q;
  assign data_o = data_q;

endmodule

// File: rtl/uart_text_ctrl.sv
// -----------------------------------------------------------------------------
// uart_text_ctrl
// Turns received UART bytes into character-buffer writes and tracks a text
// cursor. Printables are written at the cursor; CR, LF, BS move the cursor;
// FF clears the screen (one write per cycle) and homes the cursor; ESC,row,col
// positions the cursor with clamping.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus (master) : rx_valid_i/rx_data_i in; wr_en_o/wr_addr_o/wr_data_o,
//                  cur_row_o/cur_col_o, busy_o, ovf_o out
// One byte received during a clear is held and processed right after the
// sweep; a further byte in that window is dropped and flagged on ovf_o.
// -----------------------------------------------------------------------------
module uart_text_ctrl
  import uart_text_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  uart_text_ctrl_if.master  bus
);

  localparam int CELLS = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

  // Byte events from the receiver level.
  logic       strb_evt;
  logic [7:0] strb_byte;

  uart_byte_strobe u_strobe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (bus.rx_valid_i),
    .data_i  (bus.rx_data_i),
    .evt_o   (strb_evt),
    .data_o  (strb_byte)
  );

  state_e            state_q,    state_d;
  logic [ROW_W-1:0]  row_q,      row_d;
  logic [COL_W-1:0]  col_q,      col_d;
  logic [ROW_W-1:0]  esc_row_q,  esc_row_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              wr_en_q,    wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
  logic [7:0]        wr_data_q,  wr_data_d;
  logic              busy_q,     busy_d;
  logic              ovf_q,      ovf_d;
  logic              pend_full_q, pend_full_d;
  logic [7:0]        pend_data_q, pend_data_d;

  // Linear buffer address of the current (pre-update) cursor.
  logic [ADDR_W-1:0] cur_addr;
  assign cur_addr = ADDR_W'(int'(row_q) * COLS + int'(col_q));

  // Byte actually consumed this cycle (pending entry has priority).
  logic       in_evt;
  logic [7:0] in_byte;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      esc_row_q   <= '0;
      clr_addr_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      pend_full_q <= 1'b0;
      pend_data_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      esc_row_q   <= esc_row_d;
      clr_addr_q  <= clr_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      pend_full_q <= pend_full_d;
      pend_data_q <= pend_data_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    esc_row_d   = esc_row_q;
    clr_addr_d  = clr_addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = 1'b0;
    ovf_d       = ovf_q;
    pend_full_d = pend_full_q;
    pend_data_d = pend_data_q;
    in_evt      = 1'b0;
    in_byte     = 8'h00;

    if (state_q == ST_CLEAR) begin
      // The sweep owns the write port; incoming bytes go to the entry.
      wr_en_d    = 1'b1;
      wr_addr_d  = clr_addr_q;
      wr_data_d  = SPACE;
      busy_d     = 1'b1;
      clr_addr_d = clr_addr_q + ADDR_W'(1);
      if (clr_addr_q == LAST_ADDR) begin
        state_d    = ST_IDLE;
        clr_addr_d = '0;
      end
      if (strb_evt) begin
        if (!pend_full_q) begin
          pend_full_d = 1'b1;
          pend_data_d = strb_byte;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end else begin
      // Drain the entry first; a fresh event in the same cycle refills it.
      if (pend_full_q) begin
        in_evt      = 1'b1;
        in_byte     = pend_data_q;
        pend_full_d = strb_evt;
        if (strb_evt) begin
          pend_data_d = strb_byte;
        end
      end else begin
        in_evt  = strb_evt;
        in_byte = strb_byte;
      end

      if (in_evt) begin
        unique case (state_q)
          ST_IDLE: begin
            if (is_printable(in_byte)) begin
              wr_en_d   = 1'b1;
              wr_addr_d = cur_addr;
              wr_data_d = in_byte;
              if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
              end else begin
                col_d = col_q + COL_W'(1);
              end
            end else begin
              case (in_byte)
                CR: col_d = '0;
                LF: begin
                  col_d = '0;
                  row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
                end
                BS: begin
                  if (col_q != '0) begin
                    // Address of the post-move cursor (same row).
                    col_d     = col_q - COL_W'(1);
                    wr_en_d   = 1'b1;
                    wr_addr_d = cur_addr - ADDR_W'(1);
                    wr_data_d = SPACE;
                  end
                end
                FF: begin
                  row_d      = '0;
                  col_d      = '0;
                  clr_addr_d = '0;
                  state_d    = ST_CLEAR;
                end
                ESC:     state_d = ST_ESC_ROW;
                default: ;
              endcase
            end
          end
          ST_ESC_ROW: begin
            esc_row_d = (int'(in_byte) >= ROWS) ? LAST_ROW : in_byte[ROW_W-1:0];
            state_d   = ST_ESC_COL;
          end
          ST_ESC_COL: begin
            row_d   = esc_row_q;
            col_d   = (int'(in_byte) >= COLS) ? LAST_COL : in_byte[COL_W-1:0];
            state_d = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.wr_en_o   = wr_en_q;
  assign bus.wr_addr_o = wr_addr_q;
  assign bus.wr_data_o = wr_data_q;
  assign bus.cur_row_o = row_q;
  assign bus.cur_col_o = col_q;
  assign bus.busy_o    = busy_q;
  assign bus.ovf_o     = ovf_q;

endmodule

// File: tb/tb_uart_text_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_text_ctrl
// Scoreboard bench for uart_text_ctrl. Each byte sent is applied to a
// character-grid model that pushes the writes it implies into a queue; a
// monitor pops and compares on every wr_en_o cycle. Cursor and flags are
// compared against the model between bytes.
// -----------------------------------------------------------------------------
module tb_uart_text_ctrl;
  import uart_text_pkg::*;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic rst;
  always #4 clk = ~clk;

  uart_text_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  uart_text_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks    = 0;
  int  n_pass      = 0;
  int  busy_cycles = 0;
  bit  mon_en      = 1'b0;

  // Reference model: cursor position plus ESC argument phase.
  int m_row = 0, m_col = 0, m_esc = 0, m_esc_row = 0;
  int exp_ovf = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void push_wr(input int a, input int d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endfunction

  function automatic void model_reset();
    m_row = 0; m_col = 0; m_esc = 0; m_esc_row = 0; exp_ovf = 0;
    exp_q.delete();
  endfunction

  function automatic void model_byte(input int b);
    if (m_esc == 1) begin
      m_esc_row = (b >= ROWS) ? ROWS - 1 : b;
      m_esc     = 2;
    end else if (m_esc == 2) begin
      m_row = m_esc_row;
      m_col = (b >= COLS) ? COLS - 1 : b;
      m_esc = 0;
    end else if (b >= 32 && b <= 126) begin
      int p;
      p = m_row * COLS + m_col;
      push_wr(p, b);
      p = (p + 1) % CELLS;
      m_row = p / COLS;
      m_col = p % COLS;
    end else begin
      case (b)
        13: m_col = 0;
        10: begin m_col = 0; m_row = (m_row + 1) % ROWS; end
        8:  if (m_col > 0) begin m_col--; push_wr(m_row * COLS + m_col, 32); end
        12: begin
          m_row = 0; m_col = 0;
          for (int a = 0; a < CELLS; a++) push_wr(a, 32);
        end
        27: m_esc = 1;
        default: ;
      endcase
    end
  endfunction

  // Drive one byte as a level held for 'hold' cycles; apply it to the model.
  task automatic send(input int b, input int hold, input int gap, input bit lost = 1'b0);
    @(negedge clk);
    bus.rx_data_i  = 8'(b);
    bus.rx_valid_i = 1'b1;
    if (lost) exp_ovf = 1;
    else model_byte(b);
    repeat (hold) @(negedge clk);
    bus.rx_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy_o) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) check("wait_idle_timeout_pending_writes", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_row"}, int'(bus.cur_row_o), m_row);
    check({tag, "_col"}, int'(bus.cur_col_o), m_col);
  endtask

  // Monitor: every buffer write must match the next expected write.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.busy_o) busy_cycles++;
      if (bus.wr_en_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: addr %0d data 0x%02h with none expected",
                   bus.wr_addr_o, bus.wr_data_o);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          check("wr_addr", int'(bus.wr_addr_o), w.addr);
          check("wr_data", int'(bus.wr_data_o), w.data);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_wr_en",   int'(bus.wr_en_o),   0);
    check("rst_wr_addr", int'(bus.wr_addr_o), 0);
    check("rst_wr_data", int'(bus.wr_data_o), 0);
    check("rst_row",     int'(bus.cur_row_o), 0);
    check("rst_col",     int'(bus.cur_col_o), 0);
    check("rst_busy",    int'(bus.busy_o),    0);
    check("rst_ovf",     int'(bus.ovf_o),     0);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Long-held 'A' gives exactly one write at address 0.
    send(8'h41, 500, 5);
    wait_idle();
    check_cursor("t1");

    // Bottom-right printable wraps cursor to home; clamped ESC positioning.
    send(27, 2, 3); send(29, 2, 3); send(79, 2, 3);
    check_cursor("t2_esc");
    send(8'h5A, 3, 4);
    wait_idle();
    check_cursor("t2_wrap");
    send(27, 2, 3); send(200, 2, 3); send(200, 2, 4);
    check_cursor("t2_clamp");

    // CR / LF / BS behaviour.
    send(27, 2, 3); send(3, 2, 3); send(5, 2, 4);
    send(13, 2, 4);  check_cursor("t3_cr");
    send(10, 2, 4);  check_cursor("t3_lf");
    send(8, 2, 4);   check_cursor("t3_bs_col0");
    send(8'h78, 2, 4);
    send(8, 2, 4);
    wait_idle();
    check_cursor("t3_bs");

    // Clear with one byte arriving mid-sweep.
    busy_cycles = 0;
    send(12, 2, 100);
    send(8'h51, 2, 4);
    wait_idle();
    check("t4_busy_cycles", busy_cycles, CELLS);
    check("t4_ovf", int'(bus.ovf_o), exp_ovf);
    check_cursor("t4");

    // Two bytes during a clear: first kept, second lost and flagged.
    send(12, 2, 50);
    send(8'h6D, 2, 50);
    send(8'h6E, 2, 50, 1'b1);
    wait_idle();
    check("t5_ovf", int'(bus.ovf_o), exp_ovf);
    check_cursor("t5");

    // Randomised byte stream.
    for (int i = 0; i < 150; i++) begin
      int sel, b;
      sel = int'($urandom_range(0, 9));
      if (sel <= 4)      b = int'($urandom_range(32, 126));
      else if (sel == 5) b = 13;
      else if (sel == 6) b = 10;
      else if (sel == 7) b = 8;
      else if (sel == 8) b = 27;
      else begin
        b = int'($urandom_range(0, 255));
        if (b == 12) b = 0;
      end
      send(b, int'($urandom_range(1, 12)), int'($urandom_range(3, 8)));
      if (sel == 8) begin
        send(int'($urandom_range(0, 255)), int'($urandom_range(1, 6)), 3);
        send(int'($urandom_range(0, 255)), int'($urandom_range(1, 6)), 4);
      end
      check_cursor("rand");
    end
    wait_idle();
    check("rand_ovf_sticky", int'(bus.ovf_o), exp_ovf);

    // Reset in the middle of a clear.
    send(12, 2, 0);
    begin
      int n = 0;
      while (!(bus.wr_en_o && bus.wr_addr_o == 12'd1000) && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 3000) check("t6_reach_addr_1000_timeout", n, 0);
    end
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check("t6_wr_en",   int'(bus.wr_en_o),   0);
    check("t6_wr_addr", int'(bus.wr_addr_o), 0);
    check("t6_wr_data", int'(bus.wr_data_o), 0);
    check("t6_row",     int'(bus.cur_row_o), 0);
    check("t6_col",     int'(bus.cur_col_o), 0);
    check("t6_busy",    int'(bus.busy_o),    0);
    check("t6_ovf",     int'(bus.ovf_o),     0);
    model_reset();
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h41, 20, 5);
    wait_idle();
    check_cursor("t6_after");
    check("t6_ovf_after", int'(bus.ovf_o), exp_ovf);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_text_ctrl.md
# uart_text_ctrl

Byte-stream controller between the UART receiver and the VGA character buffer. It turns each received byte into at most one character-buffer write per clock, and tracks a text cursor. It interprets a small control-character set: CR, LF, BS, FF clear-screen, and ESC cursor positioning. It is the only writer of the text buffer's write port.

## Interface
Parameters:
- COLS, 80, characters per row (640 px / 8 px font)
- ROWS, 30, character rows (480 px / 16 px font)
- ADDR_W, 12, buffer address width; COLS*ROWS ≤ 2**ADDR_W required

Ports:
- clk_i  in  1  system clock (122.61 MHz)
- rst_i  in  1  reset, asynchronous, active-high
- rx_valid_i  in  1  UART receiver `wr_o`; level, high for many cycles per byte
- rx_data_i  in  8  UART receiver `data_o`; stable while rx_valid_i high
- wr_en_o  out  1  buffer write strobe, one cycle per write
- wr_addr_o  out  ADDR_W  buffer address, row*COLS+col
- wr_data_o  out  8  character code written
- cur_row_o  out  5  cursor row, 0..ROWS-1
- cur_col_o  out  7  cursor column, 0..COLS-1
- busy_o  out  1  high while a clear-screen sweep is in progress
- ovf_o  out  1  sticky; a byte was lost during a clear

## Operation
- Byte event: rx_valid_i=1 and the registered previous value=0. This is a rising edge; a level held high produces exactly one event.
- States: IDLE, ESC_ROW, ESC_COL, CLEAR.
- IDLE, printable byte 0x20–0x7E:
  - Write the byte at the cursor, then advance col.
  - col=COLS-1 → col 0, row+1.
  - row=ROWS-1 and col=COLS-1 → cursor wraps to 0,0 (no scrolling).
- IDLE, 0x0D (CR): col←0, no write.
- IDLE, 0x0A (LF): col←0 and row+1; from the last row it wraps to row 0. No write.
- IDLE, 0x08 (BS):
  - col>0: col−1, then write 0x20 at the new position.
  - col=0: no move, no write.
- IDLE, 0x0C (FF): cursor←0,0, go to CLEAR.
- IDLE, 0x1B (ESC): go to ESC_ROW.
- IDLE, any other byte: ignored.
- ESC_ROW: the next byte is the row, clamped to ROWS-1 if ≥ROWS. Any value is accepted, including control codes. Go to ESC_COL.
- ESC_COL: the next byte is the column, clamped to COLS-1. Update the cursor, go to IDLE. No writes in either ESC state.
- CLEAR:
  - Write 0x20 to addresses 0..COLS*ROWS-1 in ascending order, one per cycle.
  - Return to IDLE after the last address.
- Pending byte (one-entry buffer):
  - A byte event during CLEAR is stored in the entry.
  - It is processed as an IDLE event in the cycle after the last clear write.
  - A second event while the entry is full drops the new byte and sets ovf_o.
- Cursor arithmetic: plain registers with explicit wrap compares, never modulo. The address is computed from the post-update cursor for BS and the pre-update cursor for printables.

## Timing
- Reset (async assert): state IDLE, prev-valid 0, pending empty, and all outputs 0. This covers wr_en_o, wr_addr_o, wr_data_o, cur_row_o, cur_col_o, busy_o and ovf_o.
- Reset mid-CLEAR aborts the sweep immediately; no further writes occur. Deassertion is synchronised externally.
- Event sampled at edge k:
  - wr_en_o, wr_addr_o and wr_data_o are registered and valid between edges k and k+1 only.
  - The cursor outputs update at edge k.
- FF at edge k:
  - Clear writes appear in cycles k+1..k+COLS*ROWS.
  - busy_o is high for exactly those cycles.
  - A pending byte yields its write in cycle k+COLS*ROWS+1.
- wr_en_o is never high for two sources in one cycle. CLEAR owns the port until it completes.
- Throughput: 1 byte/cycle minimum. The UART byte period (~10.6k cycles) exceeds the clear duration (2400 cycles), so ovf_o indicates a protocol fault only.

## Structure
- Package uart_text_pkg holds:
  - control-code constants (CR, LF, BS, FF, ESC, SPACE, PRINT_MIN, PRINT_MAX)
  - the state enum
  - default COLS/ROWS
- Sub-module uart_byte_strobe: registers rx_valid_i and rx_data_i and emits a one-cycle event with the captured byte. It is reusable by future UART consumers.
- The cursor/address logic and the FSM stay in the top module.

## Test plan
- Reset, then send 'A' (0x41), with rx_valid_i held 500 cycles → exactly one write: addr 0, data 0x41. Cursor ends at 0,1.
- Send ESC,29,79 then 'Z' → write addr 2399, data 0x5A; cursor wraps to 0,0. ESC,200,200 → cursor clamps to 29,79.
- Cursor at 3,5: CR → 3,0. LF → 4,0. BS at col 0 → no write. 'x' then BS → write 0x20 at addr 320, cursor 4,0.
- FF, then 'Q' 100 cycles later → 2400 writes of 0x20 over addr 0..2399 with busy_o high for 2400 cycles. Then 'Q' at addr 0; ovf_o stays 0.
- During a clear, send two bytes → the first is written after the sweep; ovf_o=1 and stays set until reset.
- Assert rst_i at clear address 1000 → wr_en_o falls the same cycle; all outputs 0; the next 'A' writes addr 0.
